mul_64b_arbiter: RTL and testbench

- Shares a single combinational mul_64b instance (ports in0, in1, out0) among NREQ requesters.
- Each requester has a valid/ready handshake. Grants rotate round-robin.
- Operands are registered into the multiplier and the 128-bit product is registered out, tagged with the requester ID.
- Sits between client datapaths and the one 64x64 multiplier of the benchmark circuit, so that exact and approximate mul_64b netlists can be swapped in under realistic contention.

---
 rtl/mul_64b_arbiter.sv | 143 ++++++++++++++
 tb/tb_mul_64b_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_64b_arbiter.sv
// Round-robin arbiter sharing one combinational 64x64 unsigned multiplier among NREQ requesters,
// with a registered-operand stage (S1) and a registered-product stage (S2) under valid/ready flow control.

module mul_64b (
    input  logic [63:0]  in0,
    input  logic [63:0]  in1,
    output logic [127:0] out0
);
    assign out0 = {64'd0, in0} * {64'd0, in1};
endmodule

module mul_64b_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_in0,
    input  logic [64*NREQ-1:0]   req_in1,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [127:0]         res_out0,
    output logic [IDW-1:0]       res_id,
    output logic [CNTW-1:0]      op_count,
    output logic                 busy
);
    localparam int NSLOT = 2 ** IDW;

    logic                 s1_v_reg;
    logic [63:0]          s1_a_reg;
    logic [63:0]          s1_b_reg;
    logic [IDW-1:0]       s1_id_reg;
    logic                 s2_v_reg;
    logic [127:0]         s2_prod_reg;
    logic [IDW-1:0]       s2_id_reg;
    logic [IDW-1:0]       rr_ptr_reg;
    logic [CNTW-1:0]      op_count_reg;

    logic                 s1_adv;
    logic                 s2_adv;
    logic [NREQ-1:0]      upper_mask;
    logic [NREQ-1:0]      masked_req;
    logic [NREQ-1:0]      pick_req;
    logic [NREQ-1:0]      grant_onehot;
    logic                 grant_any;
    logic [IDW-1:0]       grant_id;
    logic [IDW-1:0]       rr_ptr_next;
    logic                 accept;
    logic [127:0]         mul_out;
    logic [63:0]          op_a [NSLOT];
    logic [63:0]          op_b [NSLOT];

    // Operand lanes padded to a power of two so the granted ID indexes them directly.
    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_lane
            if (gi < NREQ) begin : g_used
                assign op_a[gi] = req_in0[64*gi +: 64];
                assign op_b[gi] = req_in1[64*gi +: 64];
            end else begin : g_pad
                assign op_a[gi] = '0;
                assign op_b[gi] = '0;
            end
        end

        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign upper_mask[gi] = (IDW'(gi) >= rr_ptr_reg);
        end
    endgenerate

    // Requesters at or above the pointer win first; otherwise wrap to the lowest index.
    assign masked_req   = req_valid & upper_mask;
    assign pick_req     = (|masked_req) ? masked_req : req_valid;
    assign grant_onehot = pick_req & (~pick_req + NREQ'(1));
    assign grant_any    = |req_valid;

    genvar gb;
    generate
        for (gb = 0; gb < IDW; gb++) begin : g_enc
            logic [NREQ-1:0] bit_sel;
            for (gi = 0; gi < NREQ; gi++) begin : g_bit
                assign bit_sel[gi] = (((gi >> gb) & 1) != 0);
            end
            assign grant_id[gb] = |(grant_onehot & bit_sel);
        end
    endgenerate

    assign s2_adv      = !s2_v_reg || res_ready;
    assign s1_adv      = !s1_v_reg || s2_adv;
    assign accept      = grant_any && s1_adv && !rst;
    assign req_ready   = accept ? grant_onehot : '0;
    assign rr_ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    mul_64b u_mul (
        .in0  (s1_a_reg),
        .in1  (s1_b_reg),
        .out0 (mul_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_reg     <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_id_reg    <= '0;
            s2_v_reg     <= 1'b0;
            s2_prod_reg  <= '0;
            s2_id_reg    <= '0;
            rr_ptr_reg   <= '0;
            op_count_reg <= '0;
        end else begin
            if (s2_adv) begin
                s2_v_reg    <= s1_v_reg;
                s2_prod_reg <= mul_out;
                s2_id_reg   <= s1_id_reg;
            end
            if (s1_adv) begin
                s1_v_reg <= grant_any;
                if (grant_any) begin
                    s1_a_reg  <= op_a[grant_id];
                    s1_b_reg  <= op_b[grant_id];
                    s1_id_reg <= grant_id;
                end
            end
            if (accept) begin
                rr_ptr_reg <= rr_ptr_next;
            end
            if (s2_v_reg && res_ready) begin
                op_count_reg <= op_count_reg + CNTW'(1);
            end
        end
    end

    assign res_valid = s2_v_reg;
    assign res_out0  = s2_prod_reg;
    assign res_id    = s2_id_reg;
    assign op_count  = op_count_reg;
    assign busy      = s1_v_reg || s2_v_reg;

endmodule

// File: tb/tb_mul_64b_arbiter.sv
// Bench for mul_64b_arbiter: directed vectors, multi-cycle corner sequences and a random stream,
// all cross-checked every cycle against a queue-based reference of accepted-but-undelivered products.

module tb_mul_64b_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [64*NREQ-1:0]  req_in0 = '0;
    logic [64*NREQ-1:0]  req_in1 = '0;
    logic                res_valid;
    logic                res_ready = 1'b1;
    logic [127:0]        res_out0;
    logic [IDW-1:0]      res_id;
    logic [CNTW-1:0]     op_count;
    logic                busy;

    mul_64b_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in0   (req_in0),
        .req_in1   (req_in1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out0  (res_out0),
        .res_id    (res_id),
        .op_count  (op_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: outstanding products in acceptance order, plus the round-robin pointer rule.
    typedef struct {
        int           id;
        logic [127:0] prod;
        longint       edge_at;
    } item_t;

    item_t  q[$];
    int     m_ptr   = 0;
    longint m_count = 0;
    longint edge_n  = 0;

    always @(posedge clk) edge_n++;

    always @(negedge clk) begin
        int              g;
        logic [NREQ-1:0] exp_rdy;
        bit              exp_rv;
        item_t           it;
        if (rst) begin
            q.delete();
            m_ptr   = 0;
            m_count = 0;
        end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            exp_rdy = (g >= 0 && (q.size() < 2 || res_ready)) ? NREQ'(1 << g) : '0;
            chk("req_ready", 128'(req_ready), 128'(exp_rdy));
            exp_rv = (q.size() > 0) && (edge_n >= q[0].edge_at + 2);
            chk("res_valid", 128'(res_valid), 128'(exp_rv));
            if (res_valid && exp_rv) begin
                chk("res_out0", res_out0, q[0].prod);
                chk("res_id", 128'(res_id), 128'(q[0].id));
            end
            chk("op_count", 128'(op_count), 128'(m_count[CNTW-1:0]));
            chk("busy", 128'(busy), 128'(q.size() > 0));
            if (res_valid && res_ready && q.size() > 0) begin
                void'(q.pop_front());
                m_count++;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    it.id      = i;
                    it.prod    = {64'd0, req_in0[64*i +: 64]} * {64'd0, req_in1[64*i +: 64]};
                    it.edge_at = edge_n;
                    q.push_back(it);
                    m_ptr = (i + 1) % NREQ;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("drain", 128'(busy), 128'(0));
        tick();
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'd1 << $urandom_range(0, 63);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    typedef struct {
        int           id;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t            vt [6];
        int              n;
        int              acc;
        int              cyc;
        logic [NREQ-1:0] hs;

        vt[0] = '{0, 64'd3, 64'd5, 128'd15};
        vt[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vt[2] = '{3, 64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000};
        vt[3] = '{2, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 128'd0};
        vt[4] = '{1, 64'h1_0000_0000, 64'h1_0000_0000, 128'h1_0000_0000_0000_0000};
        vt[5] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 128'h1_FFFF_FFFF_FFFF_FFFE};

        // Reset state, with every requester asking.
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_res_out0", res_out0, 128'd0);
        chk("rst_res_id", 128'(res_id), 128'(0));
        chk("rst_op_count", 128'(op_count), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Directed single operations: grant, two-cycle latency, product, id, counter.
        for (int v = 0; v < 6; v++) begin
            req_in0[64*vt[v].id +: 64] = vt[v].a;
            req_in1[64*vt[v].id +: 64] = vt[v].b;
            req_valid = NREQ'(1 << vt[v].id);
            for (n = 1; n <= 20; n++) begin
                @(negedge clk);
                if (req_ready[vt[v].id]) break;
            end
            chk("vec_grant_wait", 128'(n), 128'(1));
            tick();
            req_valid = '0;
            for (n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (res_valid) break;
            end
            chk("vec_latency", 128'(n), 128'(2));
            chk("vec_product", res_out0, vt[v].exp);
            chk("vec_id", 128'(res_id), 128'(vt[v].id));
            tick();
            chk("vec_op_count", 128'(op_count), 128'(v + 1));
        end

        // Round-robin with all requesters held valid.
        pulse_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_in0[64*i +: 64] = 64'(i + 1);
            req_in1[64*i +: 64] = 64'd10;
        end
        res_ready = 1'b1;
        req_valid = '1;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("rr_valid", 128'(res_valid), 128'(1));
            chk("rr_id", 128'(res_id), 128'(k % NREQ));
            chk("rr_product", res_out0, 128'((k % NREQ + 1) * 10));
        end
        tick();
        req_valid = '0;
        wait_idle();

        // Backpressure: stream on requester 2 while the consumer stalls.
        res_ready = 1'b0;
        req_in0[64*2 +: 64] = 64'd100;
        req_in1[64*2 +: 64] = 64'd7;
        req_valid = 4'b0100;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (req_ready[2]) acc++;
            if (res_valid) begin
                chk("bp_hold_out0", res_out0, 128'd700);
                chk("bp_hold_id", 128'(res_id), 128'(2));
            end
            tick();
            req_in0[64*2 +: 64] = 64'(100 + acc);
        end
        chk("bp_accepts", 128'(acc), 128'(2));
        req_valid = '0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain0", res_out0, 128'd700);
        tick();
        @(negedge clk);
        chk("bp_drain1", res_out0, 128'd707);
        chk("bp_drain1_v", 128'(res_valid), 128'(1));
        wait_idle();

        // Reset while both stages are full.
        res_ready = 1'b0;
        req_in0[63:0] = 64'd9;
        req_in1[63:0] = 64'd9;
        req_valid = 4'b0001;
        repeat (3) tick();
        chk("mid_full", 128'({busy, res_valid}), 128'(2'b11));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_res_valid", 128'(res_valid), 128'(0));
        chk("mid_res_out0", res_out0, 128'd0);
        chk("mid_res_id", 128'(res_id), 128'(0));
        chk("mid_busy", 128'(busy), 128'(0));
        chk("mid_op_count", 128'(op_count), 128'(0));
        chk("mid_req_ready", 128'(req_ready), 128'(0));
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_in0[64*i +: 64] = 64'(i + 20);
            req_in1[64*i +: 64] = 64'd3;
        end
        req_valid = '1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("restart_grant", 128'(req_ready), 128'(4'b0001));
        tick();
        req_valid = '0;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        chk("restart_id", 128'(res_id), 128'(0));
        chk("restart_product", res_out0, 128'd60);
        tick();
        chk("restart_op_count", 128'(op_count), 128'(1));
        wait_idle();

        // Random stream against the reference queue.
        pulse_reset();
        acc = 0;
        for (cyc = 0; cyc < 40000; cyc++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            acc += $countones(hs);
            tick();
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] || !req_valid[i]) begin
                    if (acc < 3000 && $urandom_range(0, 1) == 1) begin
                        req_in0[64*i +: 64] = rand64();
                        req_in1[64*i +: 64] = rand64();
                        req_valid[i] = 1'b1;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            if (acc >= 3000 && req_valid == '0) break;
        end
        chk("random_progress", 128'(acc >= 3000), 128'(1));
        req_valid = '0;
        res_ready = 1'b1;
        wait_idle();
        chk("random_op_count", 128'(op_count), 128'(acc));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
